fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues word fetches over req/gnt + rvalid, queues returned
// instructions in order (each tagged with its PC) and hands them to decode over
// valid/ready. Stops fetching once the halt word is seen.
// Optional redirect support is compiled in when FETCH_REDIRECT_EN is defined.
module fetch_unit #(
    parameter int unsigned         ADDR_W      = 16,
    parameter int unsigned         DATA_W      = 16,
    parameter int unsigned         QUEUE_DEPTH = 2,
    parameter logic [ADDR_W-1:0]   RESET_PC    = 16'h0000,
    parameter logic [DATA_W-1:0]   HALT_WORD   = 16'hFFFF
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0]     out_q, out_d;     // requests granted, response not yet seen
    logic [CntW-1:0]     drop_q, drop_d;   // responses still owed to a flushed path
    logic [CntW-1:0]     cnt_q, cnt_d;     // instruction queue occupancy
    logic [PtrW-1:0]     q_wr_q, q_wr_d, q_rd_q, q_rd_d;
    logic [PtrW-1:0]     tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic [DATA_W-1:0]   q_data_q [QUEUE_DEPTH];
    logic [ADDR_W-1:0]   q_pc_q   [QUEUE_DEPTH];
    logic [ADDR_W-1:0]   tag_q    [QUEUE_DEPTH];

    logic                gnt_fire, enq, deq, redirect;
    logic [ADDR_W-1:0]   redir_target;
    logic [DATA_W-1:0]   head_data;
    logic [31:0]         credit_used;
    logic                unused_redirect;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(QUEUE_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

`ifdef FETCH_REDIRECT_EN
    assign redirect        = redirect_valid && (state_q != StHalted);
    assign redir_target    = {redirect_pc[ADDR_W-1:1], 1'b0};
    assign unused_redirect = redirect_pc[0];
`else
    assign redirect        = 1'b0;
    assign redir_target    = RESET_PC;
    assign unused_redirect = ^{redirect_valid, redirect_pc};
`endif

    // Request and decode-side outputs derived from current state.
    always_comb begin
        credit_used = 32'(out_q) + 32'(cnt_q) + 32'(drop_q);
        imem_req    = reset_n && (state_q == StRun) && (credit_used < QUEUE_DEPTH);
        imem_addr   = fetch_pc_q;
        head_data   = q_data_q[q_rd_q];
        ir_valid    = (cnt_q != '0) && (state_q != StHalted);
        ir          = ir_valid ? head_data : '0;
        ir_pc       = ir_valid ? q_pc_q[q_rd_q] : '0;
        halt        = (state_q == StHalted);
    end

    // Next-state: counters, pointers, fetch PC and FSM.
    always_comb begin
        gnt_fire   = imem_req && imem_gnt;
        enq        = imem_rvalid && (drop_q == '0) && (state_q == StRun);
        deq        = ir_valid && ir_ready;

        state_d    = state_q;
        fetch_pc_d = gnt_fire ? fetch_pc_q + ADDR_W'(2) : fetch_pc_q;
        out_d      = out_q + CntW'(gnt_fire) - CntW'(imem_rvalid);
        drop_d     = drop_q;
        cnt_d      = cnt_q + CntW'(enq) - CntW'(deq);
        q_wr_d     = enq ? ptr_inc(q_wr_q) : q_wr_q;
        q_rd_d     = deq ? ptr_inc(q_rd_q) : q_rd_q;
        tag_wr_d   = gnt_fire ? ptr_inc(tag_wr_q) : tag_wr_q;
        tag_rd_d   = imem_rvalid ? ptr_inc(tag_rd_q) : tag_rd_q;

        if (imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - CntW'(1);
        end
        if (enq && (imem_rdata == HALT_WORD)) begin
            state_d = StDrain;
        end
        if (deq && (head_data == HALT_WORD)) begin
            state_d = StHalted;
        end

        // Everything still in flight, including a grant this cycle, belongs to the old path.
        if (redirect) begin
            state_d    = StRun;
            fetch_pc_d = redir_target;
            drop_d     = out_d;
            cnt_d      = '0;
            q_wr_d     = '0;
            q_rd_d     = '0;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StRun;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            q_wr_q     <= '0;
            q_rd_q     <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            q_wr_q     <= q_wr_d;
            q_rd_q     <= q_rd_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
        end
    end

    // Storage: PC tag written at grant, instruction entry written at response.
    always_ff @(posedge clock) begin
        if (gnt_fire) begin
            tag_q[tag_wr_q] <= fetch_pc_q;
        end
        if (enq) begin
            q_data_q[q_wr_q] <= imem_rdata;
            q_pc_q[q_wr_q]   <= tag_q[tag_rd_q];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order memory model with grant gating and a
// response hold, plus a monitor recording every instruction accepted by decode.
module tb_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        halt;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    fetch_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int unsigned n_gnt   = 0;
    logic        gnt_en  = 1'b1;
    logic        rsp_hold = 1'b0;
    logic [15:0] mem [0:255];
    logic [15:0] pend [$];
    logic [15:0] cap_pc [$];
    logic [15:0] cap_ir [$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mem_default();
        for (int i = 0; i < 256; i++) mem[i] = 16'(32'h1000 + i);
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        gnt_en         = 1'b1;
        rsp_hold       = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        cap_pc.delete();
        cap_ir.delete();
        n_gnt = 0;
    endtask

    // Memory model and decode monitor; updates away from the active edge.
    initial begin
        logic [15:0] a;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                pend.delete();
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
                imem_gnt    = gnt_en;
            end else begin
                if (ir_valid && ir_ready) begin
                    cap_pc.push_back(ir_pc);
                    cap_ir.push_back(ir);
                end
                if (!rsp_hold && pend.size() > 0) begin
                    a = pend.pop_front();
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem[a[8:1]];
                end else begin
                    imem_rvalid = 1'b0;
                    imem_rdata  = '0;
                end
                imem_gnt = gnt_en;
                if (imem_req && imem_gnt) begin
                    pend.push_back(imem_addr);
                    n_gnt++;
                end
            end
        end
    end

    initial begin
        logic seen;
        reset_n        = 1'b0;
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_default();

        // Reset values while reset is held.
        step();
        step();
        check_eq("rst_req", 32'(imem_req), 0);
        check_eq("rst_addr", 32'(imem_addr), 0);
        check_eq("rst_valid", 32'(ir_valid), 0);
        check_eq("rst_ir", 32'(ir), 0);
        check_eq("rst_ir_pc", 32'(ir_pc), 0);
        check_eq("rst_halt", 32'(halt), 0);

        // Short program ending in the halt word.
        mem[0] = 16'h7101; mem[1] = 16'h720F; mem[2] = 16'h26C0; mem[3] = 16'hFFFF;
        do_reset();
        ir_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (ir_valid && ir_ready && ir == 16'hFFFF) begin
                seen = 1'b1;
                check_eq("t1_halt_before", 32'(halt), 0);
                step();
                check_eq("t1_halt_after", 32'(halt), 1);
                check_eq("t1_valid_after", 32'(ir_valid), 0);
            end else begin
                step();
            end
        end
        check_eq("t1_halt_seen", 32'(seen), 1);
        repeat (4) step();
        check_eq("t1_req_off", 32'(imem_req), 0);
        check_eq("t1_halt_sticky", 32'(halt), 1);
        check_eq("t1_count", cap_pc.size(), 4);
        if (cap_pc.size() >= 4) begin
            check_eq("t1_pc0", 32'(cap_pc[0]), 32'h0); check_eq("t1_ir0", 32'(cap_ir[0]), 32'h7101);
            check_eq("t1_pc1", 32'(cap_pc[1]), 32'h2); check_eq("t1_ir1", 32'(cap_ir[1]), 32'h720F);
            check_eq("t1_pc2", 32'(cap_pc[2]), 32'h4); check_eq("t1_ir2", 32'(cap_ir[2]), 32'h26C0);
            check_eq("t1_pc3", 32'(cap_pc[3]), 32'h6); check_eq("t1_ir3", 32'(cap_ir[3]), 32'hFFFF);
        end

        // Decode back-pressure: credit limits fetch to two words.
        mem_default();
        do_reset();
        repeat (5) step();
        check_eq("t2_ir_pc_mid", 32'(ir_pc), 0);
        check_eq("t2_ir_mid", 32'(ir), 32'h1000);
        repeat (5) step();
        check_eq("t2_gnts", n_gnt, 2);
        check_eq("t2_req_full", 32'(imem_req), 0);
        check_eq("t2_valid", 32'(ir_valid), 1);
        check_eq("t2_ir_pc_end", 32'(ir_pc), 0);
        check_eq("t2_ir_end", 32'(ir), 32'h1000);
        ir_ready = 1'b1;
        for (int i = 0; i < 80 && cap_pc.size() < 8; i++) step();
        check_eq("t2_enough", 32'(cap_pc.size() >= 8), 1);
        for (int i = 0; i < 8; i++) begin
            if (cap_pc.size() > i) begin
                check_eq("t2_pc", 32'(cap_pc[i]), 32'(2 * i));
                check_eq("t2_ir", 32'(cap_ir[i]), 32'(32'h1000 + i));
            end
        end

        // Grant stall holds the request address.
        do_reset();
        ir_ready = 1'b1;
        step();
        check_eq("t3_addr_first", 32'(imem_addr), 2);
        gnt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t3_addr_hold", 32'(imem_addr), 2);
            check_eq("t3_req_hold", 32'(imem_req), 1);
        end
        gnt_en = 1'b1;
        step();
        check_eq("t3_addr_adv", 32'(imem_addr), 4);
        repeat (4) step();
        check_eq("t3_first_pc", 32'((cap_pc.size() > 0) ? cap_pc[0] : 16'hDEAD), 0);

`ifdef FETCH_REDIRECT_EN
        // Redirect with requests outstanding; stale responses are dropped.
        do_reset();
        ir_ready = 1'b1;
        for (int i = 0; i < 20 && imem_addr != 16'h4; i++) step();
        check_eq("t4_addr4", 32'(imem_addr), 4);
        rsp_hold = 1'b1;
        for (int i = 0; i < 20 && imem_addr != 16'h6; i++) step();
        check_eq("t4_gnt4", 32'(imem_addr), 6);
        gnt_en         = 1'b0;
        ir_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0041;
        step();
        redirect_valid = 1'b0;
        check_eq("t4_valid_flush", 32'(ir_valid), 0);
        check_eq("t4_new_addr", 32'(imem_addr), 32'h40);
        cap_pc.delete();
        cap_ir.delete();
        rsp_hold = 1'b0;
        gnt_en   = 1'b1;
        ir_ready = 1'b1;
        for (int i = 0; i < 40 && cap_pc.size() < 2; i++) step();
        check_eq("t4_count", 32'(cap_pc.size() >= 2), 1);
        if (cap_pc.size() >= 2) begin
            check_eq("t4_pc0", 32'(cap_pc[0]), 32'h40); check_eq("t4_ir0", 32'(cap_ir[0]), 32'h1020);
            check_eq("t4_pc1", 32'(cap_pc[1]), 32'h42); check_eq("t4_ir1", 32'(cap_ir[1]), 32'h1021);
        end
`endif

        // Halt word at 0x0002 while 0x0004 is already granted.
        mem_default();
        mem[1] = 16'hFFFF;
        do_reset();
        ir_ready = 1'b1;
        for (int i = 0; i < 20 && imem_addr != 16'h4; i++) step();
        check_eq("t5_addr4", 32'(imem_addr), 4);
        rsp_hold = 1'b1;
        for (int i = 0; i < 20 && imem_addr != 16'h6; i++) step();
        check_eq("t5_gnt4", 32'(imem_addr), 6);
        check_eq("t5_gnts", n_gnt, 3);
        rsp_hold = 1'b0;
        for (int i = 0; i < 30 && !halt; i++) step();
        check_eq("t5_halt", 32'(halt), 1);
        repeat (3) step();
        check_eq("t5_count", cap_pc.size(), 2);
        if (cap_pc.size() >= 2) begin
            check_eq("t5_pc0", 32'(cap_pc[0]), 0);
            check_eq("t5_pc1", 32'(cap_pc[1]), 2);
            check_eq("t5_ir1", 32'(cap_ir[1]), 32'hFFFF);
        end
        check_eq("t5_gnts_end", n_gnt, 3);
        check_eq("t5_req_off", 32'(imem_req), 0);
        check_eq("t5_valid_off", 32'(ir_valid), 0);

        // Reset with a queued word and one outstanding request.
        mem_default();
        do_reset();
        for (int i = 0; i < 10 && !ir_valid; i++) step();
        check_eq("t6_valid", 32'(ir_valid), 1);
        rsp_hold = 1'b1;
        step();
        step();
        check_eq("t6_gnts", n_gnt, 2);
        check_eq("t6_req_full", 32'(imem_req), 0);
        reset_n = 1'b0;
        step();
        check_eq("t6_valid_rst", 32'(ir_valid), 0);
        check_eq("t6_addr_rst", 32'(imem_addr), 0);
        check_eq("t6_halt_rst", 32'(halt), 0);
        reset_n  = 1'b1;
        rsp_hold = 1'b0;
        cap_pc.delete();
        cap_ir.delete();
        ir_ready = 1'b1;
        for (int i = 0; i < 40 && cap_pc.size() < 2; i++) step();
        check_eq("t6_count", 32'(cap_pc.size() >= 2), 1);
        if (cap_pc.size() >= 2) begin
            check_eq("t6_pc0", 32'(cap_pc[0]), 0); check_eq("t6_ir0", 32'(cap_ir[0]), 32'h1000);
            check_eq("t6_pc1", 32'(cap_pc[1]), 2); check_eq("t6_ir1", 32'(cap_ir[1]), 32'h1001);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
